led_step_counter: RTL and testbench
===================================

# led_step_counter

Parametrised free-running/stepped binary counter for driving board LEDs. It has a prescaler, up/down direction, synchronous load and a debounce-free single-step input. The count is mirrored onto an LED bus with optional bit reversal. It sits directly between the board clock and button inputs and the LED pins, and is the general replacement for the fixed 4-bit LED counter.

## Interface
- WIDTH, 4: counter and LED width in bits (≥1).
- PRESCALE, 4: clk cycles per count step while running (≥1).
- REVERSE, 1: 1 gives led[WIDTH-1-i] = count[i]; 0 gives led[i] = count[i].

- clk  in  1  rising-edge clock; the only clock in the block.
- rst  in  1  reset; synchronous, active-low.
- en  in  1  run enable; the prescaler advances only while high.
- up  in  1  direction; 1 counts up, 0 counts down. Sampled on the step edge.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value taken by load.
- step  in  1  asynchronous button; each rising edge produces one count step.
- count  out  WIDTH  counter register.
- led  out  WIDTH  combinational permutation of count, per REVERSE.
- tick  out  1  registered; high for exactly one cycle after each count step.
- carry  out  1  registered; high for one cycle after a wrap or a saturation hit.

## Operation
- Prescaler psc, width $clog2(PRESCALE) (minimum 1 bit):
  - While en=1, psc counts 0..PRESCALE-1 and then returns to 0.
  - psc_hit = en && psc==PRESCALE-1.
  - While en=0, psc holds its value.
- Step path: step goes through a 2-flop synchronizer (s1, s2), then a rising-edge detector (s3). step_rise = s2 && !s3.
- advance = psc_hit || step_rise. If both occur in the same cycle, the counter moves only one step.
- Priority, evaluated each rising clk:
  1. rst=0.
  2. load: count <= load_val, psc <= 0, tick <= 0, carry <= 0.
  3. advance: count <= count ± 1.
  4. Otherwise hold.
- Arithmetic is modulo 2^WIDTH.
  - Up from 2^WIDTH-1 gives 0 with carry.
  - Down from 0 gives 2^WIDTH-1 with carry.
- tick <= advance && !load. carry <= (advance && wrap condition) && !load.
- led contains no register, so it changes in the same cycle as count.

## Timing
- Reset (rst=0 at a clk edge) sets count, psc, s1, s2, s3, tick and carry to 0, so led=0.
  - Because s3 resets to 0, a step held high across reset release yields exactly one step.
  - Reset asserted mid-count discards the psc progress.
- Running step period: one step every PRESCALE cycles. With PRESCALE=1, count changes on every clk edge while en=1.
- Latency from en rising (with psc=0) to the first count change: PRESCALE edges.
- Latency from step rising (setup met before edge 1) to the count change: edge 3. tick and carry are high in the cycle after edge 3.
- load takes effect at the next edge. Running resumes with a full PRESCALE period.
- Dropping en freezes count and psc. Raising en again continues from the frozen psc.
- A step pulse shorter than one clk cycle is not guaranteed to be captured.

## Configuration
- LED_COUNTER_SAT_EN:
  - Defined: the counter saturates instead of wrapping. Up at 2^WIDTH-1 stays at 2^WIDTH-1 and down at 0 stays at 0. carry pulses on each advance that hits a limit. tick still pulses.
  - Undefined: modulo wrap as described in Operation. Saturation logic is absent.

## Test plan
All scenarios use WIDTH=4, PRESCALE=4 and REVERSE=1 unless stated.
- Reset, then en=1, up=1: count becomes 1 on edge 4 after en and 2 on edge 8, with led=4'b1000 then 4'b0100. tick is high one cycle per step.
- load_val=4'hE with load for 1 cycle, then run up: count goes E, F, 0. carry is high one cycle with count=0. With LED_COUNTER_SAT_EN the count stays at F and carry pulses on each further step.
- en=0, up=0, count=3, step pulsed high for 2 cycles: count becomes 2 on the third edge after step rises, with exactly one tick.
- step_rise coincides with psc_hit: count advances by exactly 1.
- load and advance in the same cycle: count=load_val, and tick and carry stay 0.
- rst=0 applied with psc=2 and count=9: the next edge gives count=0, led=0 and psc=0. With REVERSE=0 and count=4'b0011, led=4'b0011.

Source files
------------

// File: rtl/led_step_counter.sv
// Prescaled or stepped up/down LED counter with load and bit-order option.
// Ports: clk, rst(n sync), en, up, load, load_val, step -> count, led, tick, carry. Macro: LED_COUNTER_SAT_EN.
module led_step_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4,
  parameter bit REVERSE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             carry
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LAST =
    PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PSC_ONE = PW'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE =
    WIDTH'(1);

  logic [PW-1:0]    psc_q, psc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic             tick_q, tick_d;
  logic             carry_q, carry_d;

  logic             psc_hit;
  logic             step_rise;
  logic             advance;
  logic             at_limit;
  logic [WIDTH-1:0] count_nxt;

  always_comb begin
    psc_hit   = en && (psc_q == PSC_LAST);
    step_rise = s2_q && !s3_q;
    advance   = psc_hit || step_rise;
    at_limit  = up ? (count_q == CNT_MAX)
                   : (count_q == '0);
    count_nxt = up ? count_q + CNT_ONE
                   : count_q - CNT_ONE;
`ifdef LED_COUNTER_SAT_EN
    // Pin at the rail instead of wrapping.
    if (at_limit) count_nxt = count_q;
`endif
  end

  always_comb begin
    s1_d = step;
    s2_d = s1_q;
    s3_d = s2_q;

    psc_d   = psc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;

    if (load) begin
      psc_d = '0;
    end else if (en) begin
      psc_d = psc_hit ? '0 : psc_q + PSC_ONE;
    end

    // Load wins over any step in the same cycle.
    if (load) begin
      count_d = load_val;
    end else if (advance) begin
      count_d = count_nxt;
      tick_d  = 1'b1;
      carry_d = at_limit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      psc_q   <= '0;
      count_q <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign carry = carry_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_led
    if (REVERSE) begin : g_rev
      assign led[WIDTH-1-i] = count_q[i];
    end else begin : g_fwd
      assign led[i] = count_q[i];
    end
  end

endmodule

// File: tb/tb_led_step_counter.sv
// Directed bench for led_step_counter (WIDTH=4, PRESCALE=4).
// A second REVERSE=0 instance shares the stimulus for the led order check.
module tb_led_step_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic       step;
  logic [3:0] count, led;
  logic       tick, carry;
  logic [3:0] count0, led0;
  logic       tick0, carry0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_step_counter #(
    .WIDTH(4), .PRESCALE(4), .REVERSE(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .load_val(load_val),
    .step(step), .count(count), .led(led),
    .tick(tick), .carry(carry)
  );

  led_step_counter #(
    .WIDTH(4), .PRESCALE(4), .REVERSE(1'b0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .load_val(load_val),
    .step(step), .count(count0), .led(led0),
    .tick(tick0), .carry(carry0)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1;
    load = 1'b0; load_val = 4'h0; step = 1'b0;
    cyc(2);
    chk("rst_count", count, 4'h0);
    chk("rst_led", led, 4'h0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_carry", carry, 1'b0);

    // Free run up from reset.
    rst = 1'b1; en = 1'b1; up = 1'b1;
    cyc(3);
    chk("run_e3", count, 4'h0);
    cyc(1);
    chk("run_e4", count, 4'h1);
    chk("run_e4_led", led, 4'b1000);
    chk("run_e4_tick", tick, 1'b1);
    cyc(1);
    chk("run_e5_tick", tick, 1'b0);
    cyc(3);
    chk("run_e8", count, 4'h2);
    chk("run_e8_led", led, 4'b0100);
    chk("run_e8_tick", tick, 1'b1);

    // Load E then run across the top.
    load = 1'b1; load_val = 4'hE;
    cyc(1);
    load = 1'b0;
    chk("ld_e", count, 4'hE);
    chk("ld_e_tick", tick, 1'b0);
    cyc(4);
    chk("up_f", count, 4'hF);
    chk("up_f_carry", carry, 1'b0);
    cyc(4);
`ifdef LED_COUNTER_SAT_EN
    chk("sat_hold", count, 4'hF);
`else
    chk("wrap_0", count, 4'h0);
`endif
    chk("top_carry", carry, 1'b1);
    chk("top_tick", tick, 1'b1);
    cyc(1);
    chk("top_carry_off", carry, 1'b0);
    cyc(3);
`ifdef LED_COUNTER_SAT_EN
    chk("sat_hold2", count, 4'hF);
    chk("sat_carry2", carry, 1'b1);
`else
    chk("wrap_1", count, 4'h1);
    chk("wrap_carry2", carry, 1'b0);
`endif

    // Single step down with en low.
    en = 1'b0; up = 1'b0;
    load = 1'b1; load_val = 4'h3;
    cyc(1);
    load = 1'b0;
    chk("ld3", count, 4'h3);
    chk("ld3_led_rev", led, 4'b1100);
    chk("ld3_led_fwd", led0, 4'b0011);
    step = 1'b1;
    cyc(2);
    step = 1'b0;
    chk("stp_e2", count, 4'h3);
    cyc(1);
    chk("stp_e3", count, 4'h2);
    chk("stp_e3_tick", tick, 1'b1);
    cyc(1);
    chk("stp_e4_tick", tick, 1'b0);
    cyc(4);
    chk("stp_frozen", count, 4'h2);

    // step_rise lands on the psc_hit cycle.
    en = 1'b1; up = 1'b1;
    load = 1'b1; load_val = 4'h5;
    cyc(1);
    load = 1'b0;
    cyc(1);
    step = 1'b1;
    cyc(2);
    chk("both_e3", count, 4'h5);
    cyc(1);
    chk("both_e4", count, 4'h6);
    chk("both_tick", tick, 1'b1);
    en = 1'b0; step = 1'b0;
    cyc(6);
    chk("both_hold", count, 4'h6);

    // Load collides with a down wrap from 0.
    up = 1'b0;
    load = 1'b1; load_val = 4'h0;
    cyc(1);
    load = 1'b0;
    step = 1'b1;
    cyc(2);
    load = 1'b1; load_val = 4'hA;
    cyc(1);
    load = 1'b0; step = 1'b0;
    chk("ldadv_count", count, 4'hA);
    chk("ldadv_tick", tick, 1'b0);
    chk("ldadv_carry", carry, 1'b0);
    cyc(2);
    chk("ldadv_after", count, 4'hA);

    // Down wrap from 0 by stepping.
    load = 1'b1; load_val = 4'h0;
    cyc(1);
    load = 1'b0;
    step = 1'b1;
    cyc(3);
    step = 1'b0;
`ifdef LED_COUNTER_SAT_EN
    chk("dn_sat", count, 4'h0);
`else
    chk("dn_wrap", count, 4'hF);
`endif
    chk("dn_carry", carry, 1'b1);

    // Reset mid-count discards prescaler progress.
    en = 1'b1; up = 1'b1;
    load = 1'b1; load_val = 4'h9;
    cyc(1);
    load = 1'b0;
    cyc(2);
    chk("mid_count", count, 4'h9);
    rst = 1'b0;
    cyc(1);
    chk("mid_rst_count", count, 4'h0);
    chk("mid_rst_led", led, 4'h0);
    rst = 1'b1;
    cyc(3);
    chk("mid_e3", count, 4'h0);
    cyc(1);
    chk("mid_e4", count, 4'h1);

    // Step held high across reset release.
    en = 1'b0; step = 1'b1;
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(2);
    chk("hold_e2", count, 4'h0);
    cyc(1);
    chk("hold_e3", count, 4'h1);
    cyc(5);
    chk("hold_once", count, 4'h1);
    step = 1'b0;
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
